// File: rtl/mac_entry_ctrl.sv
// mac_entry_ctrl
// Operator-entry sequencer for the floating-point MAC.
//   - Collects keypad hex digits into a 16-bit rolling entry buffer.
//   - Enter latches operand A, then operand B, and fires one MAC start.
//   - Waits for the MAC done strobe, with a cycle timeout.
//   - Holds the result for the 4-digit display.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   key_valid    one-cycle strobe: key_code carries a new hex digit
//   key_code     hex digit 0x0..0xF
//   btn_enter    one-cycle strobe: commit entry / advance
//   btn_clear    one-cycle strobe: abort back to operand-A entry
//   btn_acc_clr  one-cycle strobe: clear the accumulator with the next operation
//   mac_a/mac_b  operands to the MAC
//   mac_start    one-cycle start pulse to the MAC
//   mac_acc_clr  accumulator clear; only meaningful while mac_start is high
//   mac_done     one-cycle completion strobe from the MAC
//   mac_result   MAC result, valid while mac_done is high
//   disp_data    4-digit display word
//   state_code   current FSM state encoding
//   err          timeout flag
//   op_count     completed operations, wraps 255 -> 0
module mac_entry_ctrl #(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        btn_enter,
  input  logic        btn_clear,
  input  logic        btn_acc_clr,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic        mac_start,
  output logic        mac_acc_clr,
  input  logic        mac_done,
  input  logic [15:0] mac_result,
  output logic [15:0] disp_data,
  output logic [2:0]  state_code,
  output logic        err,
  output logic [7:0]  op_count
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  state_t      r_state, w_state_n;
  logic [15:0] r_ebuf, w_ebuf_n;
  logic [15:0] r_result, w_result_n;
  logic [15:0] r_timer, w_timer_n;
  logic        r_acc_pend, w_acc_pend_n;
  logic [15:0] w_a_n, w_b_n;
  logic        w_err_n;
  logic [7:0]  w_op_n;
  logic [15:0] w_disp_n;
  logic        w_start_n, w_acc_clr_n;

  always_comb begin
    w_state_n  = r_state;
    w_ebuf_n   = r_ebuf;
    w_result_n = r_result;
    w_timer_n  = r_timer;
    w_a_n      = mac_a;
    w_b_n      = mac_b;
    w_err_n    = err;
    w_op_n     = op_count;

    // The pending clear is consumed by the start pulse already on the wire
    // in S_RUN, even if that operation is then abandoned by btn_clear.
    w_acc_pend_n = (r_state == S_RUN) ? 1'b0 : r_acc_pend;
    if (btn_acc_clr) w_acc_pend_n = 1'b1;

    if (btn_clear) begin
      w_state_n = S_A;
      w_ebuf_n  = 16'h0000;
      w_err_n   = 1'b0;
    end else begin
      unique case (r_state)
        S_A, S_B: begin
          if (btn_enter) begin
            if (r_state == S_A) begin
              w_a_n     = r_ebuf;
              w_state_n = S_B;
            end else begin
              w_b_n     = r_ebuf;
              w_state_n = S_RUN;
            end
            w_ebuf_n = 16'h0000;
          end else if (key_valid) begin
            w_ebuf_n = {r_ebuf[11:0], key_code};
          end
        end
        S_RUN: begin
          w_timer_n = 16'h0000;
          w_state_n = S_WAIT;
        end
        S_WAIT: begin
          // done takes precedence over an expiring timer on the same cycle
          if (mac_done) begin
            w_result_n = mac_result;
            w_op_n     = op_count + 8'd1;
            w_state_n  = S_SHOW;
          end else if (r_timer == TMAX) begin
            w_err_n   = 1'b1;
            w_state_n = S_ERR;
          end else begin
            w_timer_n = r_timer + 16'd1;
          end
        end
        S_SHOW: begin
          if (btn_enter) begin
            w_a_n     = r_result;
            w_ebuf_n  = 16'h0000;
            w_state_n = S_B;
          end else if (key_valid) begin
            w_ebuf_n  = {12'h000, key_code};
            w_state_n = S_A;
          end
        end
        default: ;
      endcase
    end

    // Outputs are registered, so they are derived from the next-state values.
    w_start_n   = (w_state_n == S_RUN);
    w_acc_clr_n = w_start_n & w_acc_pend_n;

    unique case (w_state_n)
      S_A, S_B:      w_disp_n = w_ebuf_n;
      S_RUN, S_WAIT: w_disp_n = w_b_n;
      S_SHOW:        w_disp_n = w_result_n;
      default:       w_disp_n = 16'hEEEE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_A;
      r_ebuf      <= 16'h0000;
      r_result    <= 16'h0000;
      r_timer     <= 16'h0000;
      r_acc_pend  <= 1'b0;
      mac_a       <= 16'h0000;
      mac_b       <= 16'h0000;
      mac_start   <= 1'b0;
      mac_acc_clr <= 1'b0;
      disp_data   <= 16'h0000;
      state_code  <= 3'd0;
      err         <= 1'b0;
      op_count    <= 8'd0;
    end else begin
      r_state     <= w_state_n;
      r_ebuf      <= w_ebuf_n;
      r_result    <= w_result_n;
      r_timer     <= w_timer_n;
      r_acc_pend  <= w_acc_pend_n;
      mac_a       <= w_a_n;
      mac_b       <= w_b_n;
      mac_start   <= w_start_n;
      mac_acc_clr <= w_acc_clr_n;
      disp_data   <= w_disp_n;
      state_code  <= w_state_n;
      err         <= w_err_n;
      op_count    <= w_op_n;
    end
  end

endmodule

// File: tb/tb_mac_entry_ctrl.sv
module tb_mac_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid, btn_enter, btn_clear, btn_acc_clr, mac_done;
  logic [3:0]  key_code;
  logic [15:0] mac_result;
  logic [15:0] mac_a, mac_b, disp_data;
  logic        mac_start, mac_acc_clr, err;
  logic [2:0]  state_code;
  logic [7:0]  op_count;

  mac_entry_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_code(key_code),
    .btn_enter(btn_enter), .btn_clear(btn_clear), .btn_acc_clr(btn_acc_clr),
    .mac_a(mac_a), .mac_b(mac_b), .mac_start(mac_start), .mac_acc_clr(mac_acc_clr),
    .mac_done(mac_done), .mac_result(mac_result),
    .disp_data(disp_data), .state_code(state_code), .err(err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] disp;
    logic        e;
    logic [7:0]  op;
    logic        chk;
    logic [15:0] a;
    logic [15:0] b;
  } probe_t;

  logic [32:0] start_q[$];   // {mac_a, mac_b, mac_acc_clr} expected per start pulse
  probe_t      probe_q[$];
  string       name_q[$];
  logic        tb_done = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mac_start) begin
      n_vec++;
      if (start_q.size() == 0) begin
        n_bad++;
        $display("FAIL start_unexpected: got a=%h b=%h acc_clr=%b, required no start", mac_a, mac_b, mac_acc_clr);
      end else begin
        logic [32:0] ex;
        ex = start_q.pop_front();
        if ({mac_a, mac_b, mac_acc_clr} !== ex) begin
          n_bad++;
          $display("FAIL start_operands: got a=%h b=%h acc_clr=%b, required a=%h b=%h acc_clr=%b",
                   mac_a, mac_b, mac_acc_clr, ex[32:17], ex[16:1], ex[0]);
        end
      end
    end else if (mac_acc_clr) begin
      n_vec++;
      n_bad++;
      $display("FAIL acc_clr_stray: got mac_acc_clr=1 without mac_start, required 0");
    end
    if (probe_q.size() > 0) begin
      probe_t p;
      string  nm;
      p  = probe_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if ({state_code, disp_data, err, op_count} !== {p.st, p.disp, p.e, p.op} ||
          (p.chk && {mac_a, mac_b} !== {p.a, p.b})) begin
        n_bad++;
        $display("FAIL %s: got st=%0d disp=%h err=%b op=%0d a=%h b=%h, required st=%0d disp=%h err=%b op=%0d a=%h b=%h (a/b checked=%b)",
                 nm, state_code, disp_data, err, op_count, mac_a, mac_b,
                 p.st, p.disp, p.e, p.op, p.a, p.b, p.chk);
      end
    end
    if (tb_done) begin
      n_vec++;
      if (start_q.size() != 0) begin
        n_bad++;
        $display("FAIL start_missing: got %0d expected starts never seen, required 0", start_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] k);
    key_valid = 1'b1; key_code = k; step(); key_valid = 1'b0;
  endtask

  task automatic enter();
    btn_enter = 1'b1; step(); btn_enter = 1'b0;
  endtask

  task automatic clear();
    btn_clear = 1'b1; step(); btn_clear = 1'b0;
  endtask

  task automatic done(input logic [15:0] r);
    mac_done = 1'b1; mac_result = r; step(); mac_done = 1'b0; mac_result = 16'h0000;
  endtask

  task automatic probe(input string nm, input logic [2:0] st, input logic [15:0] disp,
                       input logic e, input logic [7:0] op, input logic chk,
                       input logic [15:0] a, input logic [15:0] b);
    probe_q.push_back('{st: st, disp: disp, e: e, op: op, chk: chk, a: a, b: b});
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; btn_enter = 1'b0; btn_clear = 1'b0;
    btn_acc_clr = 1'b0; mac_done = 1'b0; mac_result = 16'h0000;
    step(); step();
    rst = 1'b0;
    probe("reset", 3'd0, 16'h0000, 1'b0, 8'd0, 1'b1, 16'h0000, 16'h0000);

    // Basic operation: 3C00 x 4000, done 5 cycles after start
    key(4'h3); key(4'hC); key(4'h0); key(4'h0);
    probe("entry_a", 3'd0, 16'h3C00, 1'b0, 8'd0, 1'b0, 16'h0, 16'h0);
    enter();
    probe("to_b", 3'd1, 16'h0000, 1'b0, 8'd0, 1'b1, 16'h3C00, 16'h0000);
    key(4'h4); key(4'h0); key(4'h0); key(4'h0);
    start_q.push_back({16'h3C00, 16'h4000, 1'b0});
    enter();
    probe("run", 3'd2, 16'h4000, 1'b0, 8'd0, 1'b1, 16'h3C00, 16'h4000);
    repeat (4) step();
    done(16'h4E00);
    probe("show", 3'd4, 16'h4E00, 1'b0, 8'd1, 1'b0, 16'h0, 16'h0);

    // Chained Enter, then clear+enter in S_B
    enter();
    probe("chain", 3'd1, 16'h0000, 1'b0, 8'd1, 1'b1, 16'h4E00, 16'h4000);
    btn_clear = 1'b1; btn_enter = 1'b1; step(); btn_clear = 1'b0; btn_enter = 1'b0;
    probe("clr_over_enter", 3'd0, 16'h0000, 1'b0, 8'd1, 1'b0, 16'h0, 16'h0);

    // Rolling buffer: 5th digit pushes out the oldest
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h5);
    probe("roll", 3'd0, 16'h2345, 1'b0, 8'd1, 1'b0, 16'h0, 16'h0);
    enter();
    probe("roll_a", 3'd1, 16'h0000, 1'b0, 8'd1, 1'b1, 16'h2345, 16'h4000);
    clear();

    // Accumulator clear request rides only on the next start
    btn_acc_clr = 1'b1; step(); btn_acc_clr = 1'b0;
    key(4'h1); enter(); key(4'h2);
    start_q.push_back({16'h0001, 16'h0002, 1'b1});
    enter();
    step();
    done(16'h1234);
    probe("acc_op", 3'd4, 16'h1234, 1'b0, 8'd2, 1'b0, 16'h0, 16'h0);
    key(4'h7);
    probe("show_key", 3'd0, 16'h0007, 1'b0, 8'd2, 1'b0, 16'h0, 16'h0);
    enter(); key(4'h8);
    start_q.push_back({16'h0007, 16'h0008, 1'b0});
    enter();
    step();
    done(16'hABCD);
    probe("second_op", 3'd4, 16'hABCD, 1'b0, 8'd3, 1'b0, 16'h0, 16'h0);

    // Timeout: 16 cycles in S_WAIT with no done
    enter(); key(4'h1);
    start_q.push_back({16'hABCD, 16'h0001, 1'b0});
    enter();
    step();
    repeat (15) step();
    probe("wait_15", 3'd3, 16'h0001, 1'b0, 8'd3, 1'b0, 16'h0, 16'h0);
    step();
    probe("timeout", 3'd5, 16'hEEEE, 1'b1, 8'd3, 1'b0, 16'h0, 16'h0);
    enter(); key(4'h9);
    probe("err_sticky", 3'd5, 16'hEEEE, 1'b1, 8'd3, 1'b0, 16'h0, 16'h0);
    clear();
    probe("err_clear", 3'd0, 16'h0000, 1'b0, 8'd3, 1'b0, 16'h0, 16'h0);

    // Clear during S_WAIT abandons the operation
    key(4'h5); enter(); key(4'h6);
    start_q.push_back({16'h0005, 16'h0006, 1'b0});
    enter();
    step(); step();
    clear();
    done(16'h7777);
    probe("abandon", 3'd0, 16'h0000, 1'b0, 8'd3, 1'b1, 16'h0005, 16'h0006);

    // Done on the same cycle the timer reaches TIMEOUT-1: done wins
    enter();
    start_q.push_back({16'h0000, 16'h0000, 1'b0});
    enter();
    step();
    repeat (15) step();
    done(16'h5555);
    probe("done_at_limit", 3'd4, 16'h5555, 1'b0, 8'd4, 1'b0, 16'h0, 16'h0);

    // Reset asserted in S_RUN returns everything to reset values
    enter(); enter();
    rst = 1'b1;
    probe("rst_mid", 3'd0, 16'h0000, 1'b0, 8'd0, 1'b1, 16'h0000, 16'h0000);
    step();
    rst = 1'b0;
    step();
    probe("after_rst", 3'd0, 16'h0000, 1'b0, 8'd0, 1'b1, 16'h0000, 16'h0000);

    tb_done = 1'b1;
  end

endmodule
